seg7_scan_reader: RTL and testbench
===================================

// Module: seg7_scan_reader
// PURPOSE
//  Reads a multiplexed 3-digit 7-segment bus (8 segment lines + 3 digit selects) and recovers the displayed number.
//  Filters scan glitches, decodes each settled digit back to BCD, then converts the 3-digit BCD sample to 8-bit binary.
//  Acts as the receiving end of the counter/BCD/mux display path: a scoreboard tap in the bench and a loopback reader on silicon.
// PARAMETERS
//  STABLE_CYCLES   4        consecutive identical {dig_sel,seg_in} samples required before a digit counts as settled
//  SEG_ACTIVE_LOW  1        1: seg_in lit segment = 0 (common anode); 0: lit = 1
//  SEL_ACTIVE_LOW  1        1: dig_sel selected digit = 0; 0: selected = 1
//  TIMEOUT_CYCLES  262144   cycles without a good frame before stale asserts
// PORTS
//  clk          in   1   single clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  seg_in       in   8   [0]=A..[6]=G, [7]=DP (DP ignored)
//  dig_sel      in   3   [0]=units, [1]=tens, [2]=hundreds
//  value        out  8   last good binary value
//  digits_bcd   out  12  last good {hundreds,tens,units} BCD
//  value_valid  out  1   1-cycle pulse when value/digits_bcd update
//  err_seg      out  1   1-cycle pulse: settled pattern is not a digit 0-9
//  err_sel      out  1   1-cycle pulse: settled select has >1 digit active
//  err_range    out  1   1-cycle pulse: complete frame decodes to >255
//  stale        out  1   no good frame within TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset: value=0, digits_bcd=0, value_valid=0, all err_*=0, stale=1, capture mask=0, FSM=COLLECT, filters cleared.
//  Input: 2-FF sync on seg_in/dig_sel; polarity normalised to active-high after sync.
//  Filter: counter counts while sample equals previous; reaching STABLE_CYCLES gives ONE settle event per stable window;
//   any change restarts the count. Shorter pulses are ignored.
//  Settle event: none selected -> ignored (blanking gap); >1 selected -> err_sel; one selected -> decode seg[6:0].
//   Valid digit -> store nibble in that slot, set mask bit. Invalid -> err_seg, clear that slot's mask bit.
//   Re-settling an already captured slot overwrites it (latest wins).
//  FSM: COLLECT -> CONV1 when mask==3'b111; snapshot 3 nibbles, clear mask.
//   CONV1: acc = H*10 + T (shift-add: x<<3 + x<<1), 10-bit acc. CONV2: acc = acc*10 + U.
//   DONE: acc<=255 -> value, digits_bcd load, value_valid pulse; else err_range, outputs hold. -> COLLECT.
//  Latency: value_valid 3 cycles after the settle event completing the mask (post-sync).
//  Settle events during CONV1/CONV2/DONE still update slots/mask for the next frame; snapshot unaffected.
//  stale: counter reset on value_valid; saturates at TIMEOUT_CYCLES and sets stale; value_valid clears stale next cycle.
//  Simultaneous: err_seg/err_sel and value_valid can pulse together (different frames). rst mid-CONV: no pulse, all to reset values.
// CONFIGURATION
//  SEG7_BLANK_AS_ZERO_EN defined: all-segments-off pattern on tens/hundreds decodes as 0 (leading-zero blanking);
//   on units it is still err_seg. Undefined: blank on any slot is err_seg.
// STRUCTURE
//  Package seg7_disp_pkg: SEG_DIGIT[0:9] active-high A..G codes (0x3F,06,5B,4F,66,6D,7D,07,7F,6F), SEG_BLANK=7'h00,
//   digit index constants DIG_U/DIG_T/DIG_H, FSM state enum {COLLECT,CONV1,CONV2,DONE}.
//  Sub-module seg7_pattern_decoder: combinational 7-bit pattern -> {valid, nibble}; blank handling via macro and slot input.
//  Top holds sync, stability filter, slot regs/mask, FSM, stale counter.
// TESTING (STABLE_CYCLES=4, TIMEOUT_CYCLES=1000, active-low bus)
//  1 rst=1 2 cycles -> value=0, digits_bcd=0, value_valid=0, err_*=0, stale=1.
//  2 sel 3'b110/seg 8'hB0, 3'b101/8'hA4, 3'b011/8'hF9, 100 cycles each -> one value_valid, value=123, digits_bcd=12'h123, stale=0.
//  3 Frame 2,5,6 (8'hA4,8'h92,8'h82) -> err_range pulse, no value_valid, value stays 123.
//  4 Mid-scan 2-cycle glitch sel=3'b100 with seg=8'h80 -> no err_sel, no slot change; frame still yields 123.
//  5 Tens seg=8'hFF -> err_seg, no frame; with SEG7_BLANK_AS_ZERO_EN frame blank,blank,8'hF8 -> value=7.
//  6 Hold sel=3'b111 for 1000 cycles -> stale=1; rst asserted in CONV1 -> no value_valid, reset values.

Source files
------------

// File: rtl/seg7_disp_pkg.sv
// Shared 7-segment display definitions: active-high A..G digit codes, slot indices, reader FSM states.
// Combinational helpers only; no latency or flow control.
package seg7_disp_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] DIG_U = 2'd0;
  localparam logic [1:0] DIG_T = 2'd1;
  localparam logic [1:0] DIG_H = 2'd2;

  typedef enum logic [1:0] {COLLECT, CONV1, CONV2, DONE} state_t;

  // x*10 as two shifts and an add.
  function automatic logic [9:0] times10(input logic [9:0] x);
    return (x << 3) + (x << 1);
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Maps an active-high A..G pattern to {valid, BCD nibble}; purely combinational, no backpressure.
// SEG7_BLANK_AS_ZERO_EN: a blank pattern on the tens/hundreds slot decodes as 0.
module seg7_pattern_decoder
  import seg7_disp_pkg::*;
(
  input  logic [6:0] pattern,
  input  logic [1:0] slot,
  output logic       valid,
  output logic [3:0] nibble
);

`ifdef SEG7_BLANK_AS_ZERO_EN
  localparam bit BLANK_ZERO = 1'b1;
`else
  localparam bit BLANK_ZERO = 1'b0;
`endif

  always_comb begin
    valid  = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (pattern == SEG_DIGIT[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
    // Leading-zero blanking never applies to the units digit.
    if (BLANK_ZERO && (pattern == SEG_BLANK) && (slot != DIG_U)) begin
      valid  = 1'b1;
      nibble = 4'd0;
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers the number shown on a 3-digit multiplexed 7-seg bus; value_valid 3 cycles after the completing settle.
// No backpressure: results are pulses. SEG7_BLANK_AS_ZERO_EN enables leading-zero blanking in the decoder.
module seg7_scan_reader
  import seg7_disp_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [2:0]  dig_sel,
  output logic [7:0]  value,
  output logic [11:0] digits_bcd,
  output logic        value_valid,
  output logic        err_seg,
  output logic        err_sel,
  output logic        err_range,
  output logic        stale
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0] SEL_IDLE = SEL_ACTIVE_LOW ? 3'h7 : 3'h0;

  logic [7:0]       seg_s1, seg_s2;
  logic [2:0]       sel_s1, sel_s2;
  logic [10:0]      sample, prev;
  logic [CNT_W-1:0] stab_cnt;
  logic             settle_vld;

  assign sample = {(SEL_ACTIVE_LOW ? ~sel_s2 : sel_s2), (SEG_ACTIVE_LOW ? ~seg_s2 : seg_s2)};

  // Sync flops reset to the idle bus level so no phantom sample appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1     <= SEG_IDLE;
      seg_s2     <= SEG_IDLE;
      sel_s1     <= SEL_IDLE;
      sel_s2     <= SEL_IDLE;
      prev       <= '0;
      stab_cnt   <= '0;
      settle_vld <= 1'b0;
    end else begin
      seg_s1     <= seg_in;
      seg_s2     <= seg_s1;
      sel_s1     <= dig_sel;
      sel_s2     <= sel_s1;
      prev       <= sample;
      if (sample != prev)
        stab_cnt <= CNT_W'(1);
      else if (stab_cnt != CNT_W'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + CNT_W'(1);
      settle_vld <= (sample == prev) && (stab_cnt == CNT_W'(STABLE_CYCLES - 1));
    end
  end

  // prev holds the settled sample during the settle_vld cycle.
  logic [2:0] set_sel;
  logic       sel_none, sel_multi, dec_valid, take_frame;
  logic [1:0] slot_idx;
  logic [3:0] dec_nibble;

  assign set_sel   = prev[10:8];
  assign sel_none  = (set_sel == 3'd0);
  assign sel_multi = ((set_sel & (set_sel - 3'd1)) != 3'd0);
  assign slot_idx  = set_sel[2] ? DIG_H : (set_sel[1] ? DIG_T : DIG_U);

  seg7_pattern_decoder u_dec (
    .pattern (prev[6:0]),
    .slot    (slot_idx),
    .valid   (dec_valid),
    .nibble  (dec_nibble)
  );

  logic [2:0][3:0] slot_q, slot_nxt, snap;
  logic [2:0]      mask_q, mask_nxt;
  logic [9:0]      acc, acc_c2;
  state_t          state, state_nxt;

  always_comb begin
    slot_nxt = slot_q;
    mask_nxt = mask_q;
    if (settle_vld && !sel_none && !sel_multi) begin
      if (dec_valid) begin
        slot_nxt[slot_idx] = dec_nibble;
        mask_nxt[slot_idx] = 1'b1;
      end else begin
        mask_nxt[slot_idx] = 1'b0;
      end
    end
  end

  assign take_frame = (state == COLLECT) && (mask_nxt == 3'b111);
  assign acc_c2     = times10(acc) + {6'd0, snap[DIG_U]};

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (take_frame) state_nxt = CONV1;
      CONV1:   state_nxt = CONV2;
      CONV2:   state_nxt = DONE;
      DONE:    state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    value_valid = (state == DONE) && (acc <= 10'd255);
    err_range   = (state == DONE) && (acc > 10'd255);
  end

  // Outputs are loaded on the CONV2 edge so they are already current while value_valid pulses in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q     <= '0;
      mask_q     <= '0;
      snap       <= '0;
      acc        <= '0;
      value      <= '0;
      digits_bcd <= '0;
      err_seg    <= 1'b0;
      err_sel    <= 1'b0;
    end else begin
      slot_q  <= slot_nxt;
      mask_q  <= take_frame ? 3'b000 : mask_nxt;
      if (take_frame) snap <= slot_nxt;
      err_seg <= settle_vld && !sel_none && !sel_multi && !dec_valid;
      err_sel <= settle_vld && sel_multi;
      case (state)
        CONV1: acc <= times10({6'd0, snap[DIG_H]}) + {6'd0, snap[DIG_T]};
        CONV2: begin
          acc <= acc_c2;
          if (acc_c2 <= 10'd255) begin
            value      <= acc_c2[7:0];
            digits_bcd <= {snap[DIG_H], snap[DIG_T], snap[DIG_U]};
          end
        end
        default: ;
      endcase
    end
  end

  logic [TMO_W-1:0] stale_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stale_cnt <= TMO_W'(TIMEOUT_CYCLES);
      stale     <= 1'b1;
    end else if (value_valid) begin
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else if (stale_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
      stale     <= 1'b1;
    end else begin
      stale_cnt <= stale_cnt + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed + randomized bench for seg7_scan_reader on an active-low bus with a 1000-cycle timeout.
// Expected numbers come from digit arithmetic (100*H + 10*T + U) over an independent segment table.
module tb_seg7_scan_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [2:0]  dig_sel;
  logic [7:0]  value;
  logic [11:0] digits_bcd;
  logic        value_valid, err_seg, err_sel, err_range, stale;

  always #5 clk = ~clk;

  seg7_scan_reader #(
    .STABLE_CYCLES  (4),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .value       (value),
    .digits_bcd  (digits_bcd),
    .value_valid (value_valid),
    .err_seg     (err_seg),
    .err_sel     (err_sel),
    .err_range   (err_range),
    .stale       (stale)
  );

  // Common-anode codes, DP off.
  localparam logic [7:0] SEG_AL [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [2:0] SEL_U = 3'b110, SEL_T = 3'b101, SEL_H = 3'b011, SEL_NONE = 3'b111;

  int checks = 0;
  int errors = 0;
  int vv_n = 0, er_n = 0, es_n = 0, esel_n = 0;

  always @(negedge clk) begin
    if (value_valid) vv_n++;
    if (err_range)   er_n++;
    if (err_seg)     es_n++;
    if (err_sel)     esel_n++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; leaves the caller just after a posedge.
  task automatic drive(input logic [2:0] sel, input logic [7:0] seg, input int n);
    dig_sel = sel;
    seg_in  = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_raw(input logic [7:0] h, input logic [7:0] t, input logic [7:0] u, input int n);
    drive(SEL_U, u, n);
    drive(SEL_T, t, n);
    drive(SEL_H, h, n);
    drive(SEL_NONE, 8'hFF, 16);
  endtask

  int b_vv, b_er, b_es, b_esel;
  task automatic snap_counts();
    b_vv = vv_n; b_er = er_n; b_es = es_n; b_esel = esel_n;
  endtask

  int exp_val, exp_bcd, h, t, u, num;

  initial begin
    rst = 1'b1;
    dig_sel = SEL_NONE;
    seg_in = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_value", value, 0);
    check("rst_bcd", digits_bcd, 0);
    check("rst_valid", value_valid, 0);
    check("rst_err_seg", err_seg, 0);
    check("rst_err_sel", err_sel, 0);
    check("rst_err_range", err_range, 0);
    check("rst_stale", stale, 1);
    rst = 1'b0;
    drive(SEL_NONE, 8'hFF, 4);

    // First good frame, slow scan.
    snap_counts();
    frame_raw(SEG_AL[1], SEG_AL[2], SEG_AL[3], 100);
    check("f123_valid_n", vv_n - b_vv, 1);
    check("f123_value", value, 123);
    check("f123_bcd", digits_bcd, 12'h123);
    check("f123_stale", stale, 0);
    exp_val = 123; exp_bcd = 12'h123;

    // 256 is out of range; outputs hold.
    snap_counts();
    frame_raw(SEG_AL[2], SEG_AL[5], SEG_AL[6], 12);
    check("f256_range_n", er_n - b_er, 1);
    check("f256_valid_n", vv_n - b_vv, 0);
    check("f256_value", value, exp_val);

    // Short multi-select glitch is filtered.
    snap_counts();
    drive(SEL_U, SEG_AL[3], 12);
    drive(3'b100, 8'h80, 2);
    drive(SEL_T, SEG_AL[2], 12);
    drive(SEL_H, SEG_AL[1], 12);
    drive(SEL_NONE, 8'hFF, 16);
    check("glitch_sel_n", esel_n - b_esel, 0);
    check("glitch_seg_n", es_n - b_es, 0);
    check("glitch_valid_n", vv_n - b_vv, 1);
    check("glitch_value", value, 123);

    // A settled multi-select is reported.
    snap_counts();
    drive(3'b100, SEG_AL[8], 12);
    drive(SEL_NONE, 8'hFF, 8);
    check("multi_sel_n", esel_n - b_esel, 1);

    // Blank on units is always an error.
    snap_counts();
    drive(SEL_U, 8'hFF, 12);
    drive(SEL_NONE, 8'hFF, 8);
    check("blank_u_seg_n", es_n - b_es, 1);

    // Blank tens/hundreds: error by default, leading zeros when blanking is enabled.
    snap_counts();
    frame_raw(8'hFF, 8'hFF, SEG_AL[7], 12);
`ifdef SEG7_BLANK_AS_ZERO_EN
    check("blank_ht_valid_n", vv_n - b_vv, 1);
    check("blank_ht_seg_n", es_n - b_es, 0);
    check("blank_ht_value", value, 7);
    check("blank_ht_bcd", digits_bcd, 12'h007);
    exp_val = 7; exp_bcd = 12'h007;
`else
    check("blank_ht_valid_n", vv_n - b_vv, 0);
    check("blank_ht_seg_n", es_n - b_es, 2);
    check("blank_ht_value", value, exp_val);
`endif

    // Randomized frames against the arithmetic model.
    for (int k = 0; k < 10; k++) begin
      h = $urandom_range(0, 3);
      t = $urandom_range(0, 9);
      u = $urandom_range(0, 9);
      num = h * 100 + t * 10 + u;
      snap_counts();
      frame_raw(SEG_AL[h], SEG_AL[t], SEG_AL[u], $urandom_range(5, 20));
      if (num <= 255) begin
        exp_val = num;
        exp_bcd = (h << 8) | (t << 4) | u;
      end
      check("rnd_valid_n", vv_n - b_vv, (num <= 255) ? 1 : 0);
      check("rnd_range_n", er_n - b_er, (num > 255) ? 1 : 0);
      check("rnd_value", value, exp_val);
      check("rnd_bcd", digits_bcd, exp_bcd);
    end

    // No good frame for the whole timeout.
    drive(SEL_NONE, 8'hFF, 1010);
    check("timeout_stale", stale, 1);

    // Reset while the last frame is converting: no pulse, everything back to reset values.
    snap_counts();
    drive(SEL_U, SEG_AL[4], 12);
    drive(SEL_T, SEG_AL[5], 12);
    drive(SEL_H, SEG_AL[1], 7);
    rst = 1'b1;
    drive(SEL_NONE, 8'hFF, 2);
    rst = 1'b0;
    drive(SEL_NONE, 8'hFF, 12);
    check("rstconv_valid_n", vv_n - b_vv, 0);
    check("rstconv_value", value, 0);
    check("rstconv_bcd", digits_bcd, 0);
    check("rstconv_stale", stale, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
